move_path_recorder: RTL
=======================

// Module: move_path_recorder
// PURPOSE
//  Downstream consumer of the maze solver's move stream. Captures each qualified 2-bit move into a buffer
//  and tracks the rat's (x,y) position from a fixed start. Checks on solver done that the path is in-bounds
//  and ends at the goal. Replays the stored path one move per request to the display/host side.
// PARAMETERS
//  DEPTH    256  max moves stored (power of 2)
//  COORD_W  4    width of x and y coordinates (maze is 2^COORD_W square)
//  START_X  0    x after reset/clear;  START_Y 0  y after reset/clear
//  GOAL_X   15   required final x;      GOAL_Y  15 required final y
// PORTS
//  clk         in   1                 system clock, rising edge
//  rst         in   1                 synchronous, active-high reset
//  clear       in   1                 sync restart: empty buffer, pos<=start, flags<=0, state IDLE
//  move_valid  in   1                 move_in is a new solver move this cycle
//  move_in     in   2                 00 up(y-1), 01 right(x+1), 10 left(x-1), 11 down(y+1)
//  solver_done in   1                 solver finished with a path (1-cycle pulse or level)
//  solver_fail in   1                 solver reports no path
//  rd_req      in   1                 request next stored move (replay)
//  rd_data     out  2                 replayed move
//  rd_valid    out  1                 rd_data valid this cycle
//  rd_last     out  1                 with rd_valid: final stored move
//  count       out  $clog2(DEPTH)+1   moves stored
//  pos_x,pos_y out  COORD_W each      current tracked position
//  path_ok     out  1                 done, in-bounds, no overflow, pos==goal
//  path_err    out  1                 sticky: a move left the maze
//  overflow    out  1                 sticky: move arrived with count==DEPTH
//  failed      out  1                 solver_fail seen
// BEHAVIOUR
//  Reset/clear: state IDLE; count=0, wr/rd ptr=0, pos=(START_X,START_Y); all flags, rd_* = 0.
//  clear outranks every other input in the same cycle; rst outranks clear. Mid-op reset aborts replay.
//  States: IDLE, RECORD, READY, FAIL.
//   IDLE  : move_valid -> store, go RECORD. solver_done -> READY (empty path). solver_fail -> FAIL.
//   RECORD: move_valid stores buf[wr_ptr], wr_ptr++, count++, pos updated next edge.
//           solver_done (move_valid same cycle is stored first) -> READY. solver_fail -> FAIL.
//   READY : path_ok = !path_err && !overflow && pos==goal, registered on entry, held until clear.
//           move_valid ignored. rd_req serviced as below.
//   FAIL  : failed=1, path_ok=0; all inputs except clear/rst ignored; rd_req ignored.
//  Position: arithmetic on COORD_W bits; a move that would under/overflow sets path_err and pos holds.
//   Move still stored. path_err never clears except clear/rst.
//  Full: count==DEPTH and move_valid -> overflow=1, move dropped, pos unchanged.
//  Replay (READY only): rd_req at edge N -> rd_valid=1, rd_data=buf[rd_ptr] at N+1 (1-cycle latency).
//   rd_req may be held every cycle: one move per cycle. rd_last=1 when rd_ptr==count-1.
//   After last, rd_ptr wraps to 0: next rd_req restarts replay from the first move.
//   rd_req with count==0: no rd_valid. rd_valid is a 1-cycle pulse per accepted request.
// STRUCTURE
//  maze_pkg: move encodings (MV_UP/RIGHT/LEFT/DOWN), recorder state enum, coordinate width.
//  Sub-module move_buffer: DEPTH x 2 register array, 1 write port, 1 registered read port.
//  Top holds FSM, pointers, position tracker, flag logic.
// TESTING
//  Reset then 15x RIGHT, 15x DOWN, solver_done -> count=30, pos=(15,15), path_ok=1, path_err=0.
//  From start, UP then done -> path_err=1, pos stays (0,0), path_ok=0, count=1.
//  DEPTH+1 moves (toggle RIGHT/LEFT) -> count=DEPTH, overflow=1, path_ok=0 after done.
//  Path of 3 moves, rd_req held 4 cycles -> rd_data m0,m1,m2,m0; rd_last only on m2; rd_valid lags 1 cycle.
//  solver_fail mid-RECORD -> failed=1, rd_req gives no rd_valid; clear -> all outputs at reset values.
//  move_valid and clear same cycle -> count=0, pos=start; rst during replay -> rd_valid=0 next cycle.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared definitions for the maze move-path recorder: move encodings,
// recorder state constants and the default coordinate width.
package maze_pkg;

   // Default coordinate width: the maze is 2^COORD_W cells on a side.
   localparam int COORD_W_DEF = 4;

   // Move encoding as produced by the maze solver.
   typedef enum logic [1:0] {
      MV_UP    = 2'b00,  // y - 1
      MV_RIGHT = 2'b01,  // x + 1
      MV_LEFT  = 2'b10,  // x - 1
      MV_DOWN  = 2'b11   // y + 1
   } move_t;

   // Recorder FSM states, kept as plain constants so older tools and
   // waveform scripts that expect raw encodings keep working.
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RECORD = 2'd1;
   localparam logic [1:0] ST_READY  = 2'd2;
   localparam logic [1:0] ST_FAIL   = 2'd3;

endpackage : maze_pkg

// File: rtl/move_buffer.sv
// Move storage: DEPTH x 2-bit register array with one write port and one
// registered read port. The read register is cleared by clr_i so the replay
// data output starts from zero after reset or restart.
module move_buffer #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          clr_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [1:0]    wr_data_i,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [1:0]    rd_data_o
);

   logic [1:0] mem_q [DEPTH];
   logic [1:0] rd_data_q;

   // Write port: store one move per enabled cycle.
   // NOTE: the array has no reset; stale contents are never observable because
   // the count and pointers are reset, and leaving it unreset lets it map to RAM.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Registered read port: data appears the cycle after the read enable.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         rd_data_q <= 2'b00;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule : move_buffer

// File: rtl/move_path_recorder.sv
// Records the maze solver's move stream, tracks the rat's position from the
// start cell, judges the path when the solver finishes, and replays the stored
// moves one per request.
module move_path_recorder
   import maze_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int COORD_W = COORD_W_DEF,
   parameter int START_X = 0,
   parameter int START_Y = 0,
   parameter int GOAL_X  = 15,
   parameter int GOAL_Y  = 15
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clear_i,
   input  logic                     move_valid_i,
   input  logic [1:0]               move_i,
   input  logic                     solver_done_i,
   input  logic                     solver_fail_i,
   input  logic                     rd_req_i,
   output logic [1:0]               rd_data_o,
   output logic                     rd_valid_o,
   output logic                     rd_last_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [COORD_W-1:0]       pos_x_o,
   output logic [COORD_W-1:0]       pos_y_o,
   output logic                     path_ok_o,
   output logic                     path_err_o,
   output logic                     overflow_o,
   output logic                     failed_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0]      FULL_CNT = CW'(DEPTH);
   localparam logic [COORD_W-1:0] X_START  = COORD_W'(START_X);
   localparam logic [COORD_W-1:0] Y_START  = COORD_W'(START_Y);
   localparam logic [COORD_W-1:0] X_GOAL   = COORD_W'(GOAL_X);
   localparam logic [COORD_W-1:0] Y_GOAL   = COORD_W'(GOAL_Y);
   localparam logic [COORD_W-1:0] C_MAX    = '1;

   logic [1:0]         state_q,    state_d;
   logic [CW-1:0]      count_q,    count_d;
   logic [AW-1:0]      wr_ptr_q,   wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q,   rd_ptr_d;
   logic [COORD_W-1:0] pos_x_q,    pos_x_d;
   logic [COORD_W-1:0] pos_y_q,    pos_y_d;
   logic               path_ok_q,  path_ok_d;
   logic               path_err_q, path_err_d;
   logic               overflow_q, overflow_d;
   logic               failed_q,   failed_d;
   logic               rd_valid_q, rd_valid_d;
   logic               rd_last_q,  rd_last_d;

   logic               wr_en;
   logic               rd_en;
   logic               restart;

   assign restart = rst_i | clear_i;

   // Next-state logic: recording, position tracking, path judgement and replay.
   // NOTE: every signal driven here gets a default first, so no path through
   // the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      pos_x_d    = pos_x_q;
      pos_y_d    = pos_y_q;
      path_ok_d  = path_ok_q;
      path_err_d = path_err_q;
      overflow_d = overflow_q;
      failed_d   = failed_q;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;

      case (state_q)
         ST_IDLE, ST_RECORD: begin
            if (move_valid_i) begin
               state_d = ST_RECORD;
               if (count_q == FULL_CNT) begin
                  // Buffer full: drop the move, leave position alone.
                  overflow_d = 1'b1;
               end else begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  count_d  = count_q + 1'b1;
                  // A move off the edge is still stored, but the position
                  // holds and the path is marked bad.
                  case (move_t'(move_i))
                     MV_UP: begin
                        if (pos_y_q == '0) path_err_d = 1'b1;
                        else               pos_y_d    = pos_y_q - 1'b1;
                     end
                     MV_RIGHT: begin
                        if (pos_x_q == C_MAX) path_err_d = 1'b1;
                        else                  pos_x_d    = pos_x_q + 1'b1;
                     end
                     MV_LEFT: begin
                        if (pos_x_q == '0) path_err_d = 1'b1;
                        else               pos_x_d    = pos_x_q - 1'b1;
                     end
                     MV_DOWN: begin
                        if (pos_y_q == C_MAX) path_err_d = 1'b1;
                        else                  pos_y_d    = pos_y_q + 1'b1;
                     end
                     default: ;
                  endcase
               end
            end

            // A move arriving with done/fail is folded in before judging.
            if (solver_fail_i) begin
               state_d  = ST_FAIL;
               failed_d = 1'b1;
            end else if (solver_done_i) begin
               state_d   = ST_READY;
               path_ok_d = !path_err_d && !overflow_d &&
                           (pos_x_d == X_GOAL) && (pos_y_d == Y_GOAL);
            end
         end

         ST_READY: begin
            if (rd_req_i && (count_q != '0)) begin
               rd_en      = 1'b1;
               rd_valid_d = 1'b1;
               rd_last_d  = ({1'b0, rd_ptr_q} == (count_q - 1'b1));
               rd_ptr_d   = rd_last_d ? '0 : rd_ptr_q + 1'b1;
            end
         end

         ST_FAIL: ;

         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset and clear return everything to the start point.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its pre-edge value regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (restart) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         pos_x_q    <= X_START;
         pos_y_q    <= Y_START;
         path_ok_q  <= 1'b0;
         path_err_q <= 1'b0;
         overflow_q <= 1'b0;
         failed_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         pos_x_q    <= pos_x_d;
         pos_y_q    <= pos_y_d;
         path_ok_q  <= path_ok_d;
         path_err_q <= path_err_d;
         overflow_q <= overflow_d;
         failed_q   <= failed_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
      end
   end

   move_buffer #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_move_buffer (
      .clk_i     (clk_i),
      .clr_i     (restart),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (move_i),
      .rd_en_i   (rd_en),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (rd_data_o)
   );

   assign rd_valid_o = rd_valid_q;
   assign rd_last_o  = rd_last_q;
   assign count_o    = count_q;
   assign pos_x_o    = pos_x_q;
   assign pos_y_o    = pos_y_q;
   assign path_ok_o  = path_ok_q;
   assign path_err_o = path_err_q;
   assign overflow_o = overflow_q;
   assign failed_o   = failed_q;

endmodule : move_path_recorder
